// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline.
// Resolves load-use, branch, mul/div and data-memory wait hazards.
module pipeline_hazard_ctrl #(
  parameter int unsigned MULDIV_CYCLES = 4,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             id_valid_i,
  input  logic [4:0]       id_ra_index_w,
  input  logic [4:0]       id_rb_index_w,
  input  logic             id_uses_rb_i,
  input  logic [4:0]       ex_rd_index_r,
  input  logic             ex_mem_read_i,
  input  logic             ex_muldiv_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ready_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_id_o,
  output logic             bubble_ex_o,
  output logic             bubble_mem_o,
  output logic             bubble_wb_o,
  output logic             muldiv_done_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MD_BUSY  = 2'd1,
    MEM_WAIT = 2'd2
  } state_e;

  localparam logic [3:0] MD_LOAD = 4'(MULDIV_CYCLES - 1);

  state_e           state_q, state_d, eff_st;
  logic [3:0]       md_cnt_q, md_cnt_d;
  logic             md_done_q, md_done_d;
  logic             from_md_q, from_md_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  logic mem_wait, load_use, rb_hit, ra_hit;
  logic in_md, in_run, md_req;
  logic c_mw, c_md, c_br, c_acc, c_lu;

  logic s_if, s_id, s_ex, s_mem;
  logic f_id, b_ex, b_mem, b_wb;

  assign mem_wait = mem_req_i & ~mem_ready_i;

  assign ra_hit = id_ra_index_w == ex_rd_index_r;
  assign rb_hit = id_uses_rb_i
                & (id_rb_index_w == ex_rd_index_r);

  assign load_use = id_valid_i
                  & ex_mem_read_i
                  & (ex_rd_index_r != 5'd0)
                  & (ra_hit | rb_hit);

  // A released MEM_WAIT behaves as the state it froze, same cycle.
  always_comb begin
    if (state_q == MD_BUSY) begin
      eff_st = MD_BUSY;
    end else if (state_q == MEM_WAIT) begin
      eff_st = from_md_q ? MD_BUSY : RUN;
    end else begin
      eff_st = RUN;
    end
  end

  assign in_md  = eff_st == MD_BUSY;
  assign in_run = eff_st == RUN;
  assign md_req = ex_muldiv_i & ~md_done_q;

  assign c_mw  = mem_wait;
  assign c_md  = ~mem_wait & in_md;
  assign c_br  = ~mem_wait & in_run & branch_taken_i;
  assign c_acc = ~mem_wait & in_run
               & ~branch_taken_i & md_req;
  assign c_lu  = ~mem_wait & in_run
               & ~branch_taken_i & ~md_req
               & load_use;

  always_comb begin
    s_if  = 1'b0;
    s_id  = 1'b0;
    s_ex  = 1'b0;
    s_mem = 1'b0;
    f_id  = 1'b0;
    b_ex  = 1'b0;
    b_mem = 1'b0;
    b_wb  = 1'b0;
    unique case (1'b1)
      c_mw: begin
        s_if  = 1'b1;
        s_id  = 1'b1;
        s_ex  = 1'b1;
        s_mem = 1'b1;
        b_wb  = 1'b1;
      end
      c_md, c_acc: begin
        s_if  = 1'b1;
        s_id  = 1'b1;
        s_ex  = 1'b1;
        b_mem = 1'b1;
      end
      c_br: begin
        f_id = 1'b1;
        b_ex = 1'b1;
      end
      c_lu: begin
        s_if = 1'b1;
        s_id = 1'b1;
        b_ex = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall_if_o    = s_if  & reset_ni;
  assign stall_id_o    = s_id  & reset_ni;
  assign stall_ex_o    = s_ex  & reset_ni;
  assign stall_mem_o   = s_mem & reset_ni;
  assign flush_id_o    = f_id  & reset_ni;
  assign bubble_ex_o   = b_ex  & reset_ni;
  assign bubble_mem_o  = b_mem & reset_ni;
  assign bubble_wb_o   = b_wb  & reset_ni;
  assign muldiv_done_o = md_done_q;
  assign stall_cnt_o   = stall_cnt_q;
  assign flush_cnt_o   = flush_cnt_q;

  always_comb begin
    state_d   = state_q;
    md_cnt_d  = md_cnt_q;
    md_done_d = md_done_q;
    from_md_d = from_md_q;
    if (mem_wait) begin
      state_d   = MEM_WAIT;
      from_md_d = in_md;
    end else begin
      state_d   = eff_st;
      md_done_d = 1'b0;
      if (c_md) begin
        md_cnt_d = md_cnt_q - 4'd1;
        if (md_cnt_q == 4'd1) begin
          state_d   = RUN;
          md_done_d = 1'b1;
        end
      end else if (c_acc) begin
        if (MULDIV_CYCLES == 1) begin
          md_done_d = 1'b1;
        end else begin
          md_cnt_d = MD_LOAD;
          state_d  = MD_BUSY;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= RUN;
      md_cnt_q    <= 4'd0;
      md_done_q   <= 1'b0;
      from_md_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      md_cnt_q    <= md_cnt_d;
      md_done_q   <= md_done_d;
      from_md_q   <= from_md_d;
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall_if_o);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush_id_o);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: vector table plus corner sequences.
// Three instances: default, MULDIV_CYCLES=1, CNT_W=4.
module tb_pipeline_hazard_ctrl;

  localparam logic [7:0] F0   = 8'b0000_0000;
  localparam logic [7:0] F_LU = 8'b1100_0100;
  localparam logic [7:0] F_BR = 8'b0000_1100;
  localparam logic [7:0] F_MD = 8'b1110_0010;
  localparam logic [7:0] F_MW = 8'b1111_0001;

  typedef struct {
    logic       vld;
    logic [4:0] ra;
    logic [4:0] rb;
    logic       urb;
    logic [4:0] rd;
    logic       ld;
    logic       md;
    logic       br;
    logic       mrq;
    logic       mrd;
    logic [7:0] f;
    logic       dn;
  } vec_t;

  typedef struct {
    string       nm;
    logic [7:0]  f;
    logic        dn;
    logic [31:0] sc;
    logic [31:0] fc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic vld, urb, ld, md, br, mrq, mrd;
  logic [4:0] ra, rb, rd;

  logic [7:0]  m_f, o_f, w_f;
  logic        m_dn, o_dn, w_dn;
  logic [31:0] m_sc, m_fc, o_sc, o_fc;
  logic [3:0]  w_sc, w_fc;

  logic [7:0]  got_f;
  logic        got_dn;
  logic [31:0] got_sc, got_fc;

  int cur_sel;
  int n_pass, n_tot;
  logic [31:0] exp_sc, exp_fc;
  exp_t sbq[$];
  vec_t tbl[18];

  always #5 clk = ~clk;

  pipeline_hazard_ctrl u_main (
    .clk_i(clk), .reset_ni(rst_n),
    .id_valid_i(vld), .id_ra_index_w(ra),
    .id_rb_index_w(rb), .id_uses_rb_i(urb),
    .ex_rd_index_r(rd), .ex_mem_read_i(ld),
    .ex_muldiv_i(md), .branch_taken_i(br),
    .mem_req_i(mrq), .mem_ready_i(mrd),
    .stall_if_o(m_f[7]), .stall_id_o(m_f[6]),
    .stall_ex_o(m_f[5]), .stall_mem_o(m_f[4]),
    .flush_id_o(m_f[3]), .bubble_ex_o(m_f[2]),
    .bubble_mem_o(m_f[1]), .bubble_wb_o(m_f[0]),
    .muldiv_done_o(m_dn),
    .stall_cnt_o(m_sc), .flush_cnt_o(m_fc)
  );

  pipeline_hazard_ctrl #(.MULDIV_CYCLES(1)) u_one (
    .clk_i(clk), .reset_ni(rst_n),
    .id_valid_i(vld), .id_ra_index_w(ra),
    .id_rb_index_w(rb), .id_uses_rb_i(urb),
    .ex_rd_index_r(rd), .ex_mem_read_i(ld),
    .ex_muldiv_i(md), .branch_taken_i(br),
    .mem_req_i(mrq), .mem_ready_i(mrd),
    .stall_if_o(o_f[7]), .stall_id_o(o_f[6]),
    .stall_ex_o(o_f[5]), .stall_mem_o(o_f[4]),
    .flush_id_o(o_f[3]), .bubble_ex_o(o_f[2]),
    .bubble_mem_o(o_f[1]), .bubble_wb_o(o_f[0]),
    .muldiv_done_o(o_dn),
    .stall_cnt_o(o_sc), .flush_cnt_o(o_fc)
  );

  pipeline_hazard_ctrl #(.CNT_W(4)) u_wrap (
    .clk_i(clk), .reset_ni(rst_n),
    .id_valid_i(vld), .id_ra_index_w(ra),
    .id_rb_index_w(rb), .id_uses_rb_i(urb),
    .ex_rd_index_r(rd), .ex_mem_read_i(ld),
    .ex_muldiv_i(md), .branch_taken_i(br),
    .mem_req_i(mrq), .mem_ready_i(mrd),
    .stall_if_o(w_f[7]), .stall_id_o(w_f[6]),
    .stall_ex_o(w_f[5]), .stall_mem_o(w_f[4]),
    .flush_id_o(w_f[3]), .bubble_ex_o(w_f[2]),
    .bubble_mem_o(w_f[1]), .bubble_wb_o(w_f[0]),
    .muldiv_done_o(w_dn),
    .stall_cnt_o(w_sc), .flush_cnt_o(w_fc)
  );

  always_comb begin
    got_f  = m_f;
    got_dn = m_dn;
    got_sc = m_sc;
    got_fc = m_fc;
    if (cur_sel == 1) begin
      got_f  = o_f;
      got_dn = o_dn;
      got_sc = o_sc;
      got_fc = o_fc;
    end else if (cur_sel == 2) begin
      got_f  = w_f;
      got_dn = w_dn;
      got_sc = {28'd0, w_sc};
      got_fc = {28'd0, w_fc};
    end
  end

  function automatic vec_t mk(
    input logic vld_a, input logic [4:0] ra_a,
    input logic [4:0] rb_a, input logic urb_a,
    input logic [4:0] rd_a, input logic ld_a,
    input logic md_a, input logic br_a,
    input logic mrq_a, input logic mrd_a,
    input logic [7:0] f_a, input logic dn_a);
    vec_t v;
    v.vld = vld_a; v.ra = ra_a; v.rb = rb_a;
    v.urb = urb_a; v.rd = rd_a; v.ld = ld_a;
    v.md = md_a; v.br = br_a;
    v.mrq = mrq_a; v.mrd = mrd_a;
    v.f = f_a; v.dn = dn_a;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    vld = v.vld; ra = v.ra; rb = v.rb;
    urb = v.urb; rd = v.rd; ld = v.ld;
    md = v.md; br = v.br;
    mrq = v.mrq; mrd = v.mrd;
  endtask

  task automatic chk(input string nm,
                     input logic [7:0] f,
                     input logic dn,
                     input logic [31:0] sc,
                     input logic [31:0] fc);
    logic [31:0] m;
    m = (cur_sel == 2) ? 32'hF : 32'hFFFF_FFFF;
    n_tot++;
    if (got_f !== f || got_dn !== dn ||
        got_sc !== (sc & m) || got_fc !== (fc & m)) begin
      $display("FAIL %s: got f=%b dn=%b sc=%0d fc=%0d, want f=%b dn=%b sc=%0d fc=%0d",
               nm, got_f, got_dn, got_sc, got_fc,
               f, dn, sc & m, fc & m);
    end else begin
      n_pass++;
    end
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic apply(input vec_t v, input int sel,
                       input string nm);
    exp_t e, g;
    cur_sel = sel;
    drive(v);
    e.nm = nm; e.f = v.f; e.dn = v.dn;
    e.sc = exp_sc; e.fc = exp_fc;
    sbq.push_back(e);
    @(negedge clk);
    g = sbq.pop_front();
    chk(g.nm, g.f, g.dn, g.sc, g.fc);
    exp_sc = exp_sc + {31'd0, v.f[7]};
    exp_fc = exp_fc + {31'd0, v.f[3]};
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(mk(0,0,0,0,0,0,0,0,0,0,F0,0));
    @(negedge clk);
    rst_n = 1'b0;
    exp_sc = 0;
    exp_fc = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_pass = 0;
    n_tot = 0;
    exp_sc = 0;
    exp_fc = 0;
    cur_sel = 0;

    tbl[0]  = mk(0,0,0,0,0,0,0,0,0,0,F0,0);
    tbl[1]  = mk(1,5,0,0,5,1,0,0,0,0,F_LU,0);
    tbl[2]  = mk(1,0,0,0,0,1,0,0,0,0,F0,0);
    tbl[3]  = mk(1,3,7,1,7,1,0,0,0,0,F_LU,0);
    tbl[4]  = mk(1,3,7,0,7,1,0,0,0,0,F0,0);
    tbl[5]  = mk(0,5,0,0,5,1,0,0,0,0,F0,0);
    tbl[6]  = mk(1,5,0,0,5,1,0,1,0,0,F_BR,0);
    tbl[7]  = mk(0,0,0,0,0,0,1,1,0,0,F_BR,0);
    tbl[8]  = mk(0,0,0,0,0,0,1,0,0,0,F_MD,0);
    tbl[9]  = mk(0,0,0,0,0,0,1,0,0,0,F_MD,0);
    tbl[10] = mk(0,0,0,0,0,0,1,0,0,0,F_MD,0);
    tbl[11] = mk(0,0,0,0,0,0,1,0,0,0,F_MD,0);
    tbl[12] = mk(0,0,0,0,0,0,1,0,0,0,F0,1);
    tbl[13] = mk(0,0,0,0,0,0,0,0,0,0,F0,0);
    tbl[14] = mk(0,0,0,0,0,0,0,1,1,0,F_MW,0);
    tbl[15] = mk(0,0,0,0,0,0,0,0,1,0,F_MW,0);
    tbl[16] = mk(0,0,0,0,0,0,0,0,1,1,F0,0);
    tbl[17] = mk(1,5,0,0,5,0,0,0,0,0,F0,0);

    // Reset gating: inputs that would otherwise freeze everything.
    rst_n = 1'b0;
    drive(mk(1,5,0,0,5,1,1,1,1,0,F0,0));
    #3;
    cur_sel = 0;
    chk("reset_main", F0, 1'b0, 0, 0);
    cur_sel = 2;
    chk("reset_wrap", F0, 1'b0, 0, 0);
    drive(tbl[0]);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    foreach (tbl[i]) begin
      apply(tbl[i], 0, $sformatf("tbl%0d", i));
    end

    // Memory wait while mul/div is busy at md_cnt=2.
    apply(mk(0,0,0,0,0,0,1,0,0,0,F_MD,0), 0, "mdw1");
    apply(mk(0,0,0,0,0,0,1,0,0,0,F_MD,0), 0, "mdw2");
    for (int i = 0; i < 3; i++) begin
      apply(mk(0,0,0,0,0,0,1,0,1,0,F_MW,0), 0, "mdw_frz");
    end
    apply(mk(0,0,0,0,0,0,1,0,1,1,F_MD,0), 0, "mdw_exit");
    apply(mk(0,0,0,0,0,0,1,0,0,0,F_MD,0), 0, "mdw_last");
    apply(mk(0,0,0,0,0,0,1,0,1,0,F_MW,1), 0, "done_str");
    apply(mk(0,0,0,0,0,0,1,0,1,1,F0,1), 0, "done_norea");
    apply(mk(0,0,0,0,0,0,0,0,0,0,F0,0), 0, "done_clr");

    // MULDIV_CYCLES=1 instance.
    do_reset();
    apply(mk(0,0,0,0,0,0,1,0,0,0,F_MD,0), 1, "md1_acc");
    apply(mk(0,0,0,0,0,0,1,0,0,0,F0,1), 1, "md1_done");
    apply(mk(0,0,0,0,0,0,0,0,0,0,F0,0), 1, "md1_idle");

    // Async reset in MD_BUSY with md_cnt=2.
    do_reset();
    apply(mk(0,0,0,0,0,0,1,0,0,0,F_MD,0), 0, "ar_acc");
    apply(mk(0,0,0,0,0,0,1,0,0,0,F_MD,0), 0, "ar_busy");
    cur_sel = 0;
    #1;
    chk("ar_pre", F_MD, 1'b0, exp_sc, exp_fc);
    rst_n = 1'b0;
    exp_sc = 0;
    exp_fc = 0;
    #1;
    chk("ar_drop", F0, 1'b0, 0, 0);
    drive(tbl[0]);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    apply(mk(0,0,0,0,0,0,0,0,0,0,F0,0), 0, "ar_idle");
    apply(mk(0,0,0,0,0,0,0,1,0,0,F_BR,0), 0, "ar_run");

    // Counter wrap on the CNT_W=4 instance.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      apply(mk(1,5,0,0,5,1,0,0,0,0,F_LU,0), 2, "wrap_lu");
    end
    apply(mk(0,0,0,0,0,0,0,0,0,0,F0,0), 2, "wrap_zero");

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
